// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op codes, op width and FSM states.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] ALU_OP_AND     = 3'b000;
    localparam logic [OP_W-1:0] ALU_OP_OR      = 3'b001;
    localparam logic [OP_W-1:0] ALU_OP_ADD     = 3'b010;
    localparam logic [OP_W-1:0] ALU_OP_ILLEGAL = 3'b011;
    localparam logic [OP_W-1:0] ALU_OP_ANDN    = 3'b100;
    localparam logic [OP_W-1:0] ALU_OP_ORN     = 3'b101;
    localparam logic [OP_W-1:0] ALU_OP_SUB     = 3'b110;
    localparam logic [OP_W-1:0] ALU_OP_SLTU    = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two request channels and one response channel of the arbitrated ALU.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [31:0]       req0_a;
    logic [31:0]       req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [31:0]       req1_a;
    logic [31:0]       req1_b;
    logic [OP_W-1:0]   req1_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_id;
    logic              rsp_err;
    logic [CNT_W-1:0]  ops_done;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err, ops_done
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err, ops_done
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; the illegal code simply yields zero here.
module alu
    import alu_pkg::*;
(
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [OP_W-1:0] alucont,
    output logic [31:0]     result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (alucont)
            ALU_OP_AND:  result = a & b;
            ALU_OP_OR:   result = a | b;
            ALU_OP_ADD:  result = a + b;
            ALU_OP_ANDN: result = a & ~b;
            ALU_OP_ORN:  result = a | ~b;
            ALU_OP_SUB:  result = a - b;
            ALU_OP_SLTU: result = {31'b0, (a < b)};
            default:     result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU; one op in flight, registered response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic [31:0]       a_q, b_q;
    logic [OP_W-1:0]   op_q;
    logic              id_q;
    logic [31:0]       result_q;
    logic              zero_q, err_q, rsp_id_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              grant;
    logic              gnt0, gnt1, accept, rsp_hs;
    logic [31:0]       alu_result;
    logic              alu_zero;
    logic              illegal;

    // On a tie the requester not granted last wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
        gnt0   = rst_n && (state_q == StIdle) && bus.req0_valid && !grant;
        gnt1   = rst_n && (state_q == StIdle) && bus.req1_valid && grant;
        accept = gnt0 || gnt1;
        rsp_hs = (state_q == StResp) && bus.rsp_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    alu u_alu (
        .a       (a_q),
        .b       (b_q),
        .alucont (op_q),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    assign illegal = (op_q == ALU_OP_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            rsp_id_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (accept) begin
                a_q          <= grant ? bus.req1_a  : bus.req0_a;
                b_q          <= grant ? bus.req1_b  : bus.req0_b;
                op_q         <= grant ? bus.req1_op : bus.req0_op;
                id_q         <= grant;
                last_grant_q <= grant;
            end
            // Illegal op is forced to a zero result with error flagged.
            if (state_q == StExec) begin
                result_q <= illegal ? '0 : alu_result;
                zero_q   <= illegal ? 1'b1 : alu_zero;
                err_q    <= illegal;
                rsp_id_q <= id_q;
            end
            if (rsp_hs) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = err_q;
    assign bus.ops_done   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a behavioural reference model.
module tb_alu_arbiter;
    localparam int unsigned CNT_W = 2;
    localparam int          CNT_MOD = 1 << CNT_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.CNT_W(CNT_W)) bus ();

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int exp_last = 1;
    int exp_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return a - b;
            3'd7:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: present, accept, execute, respond (after `hold` stalled cycles).
    task automatic txn(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                       input int hold, output int gid);
        int          g;
        logic [2:0]  eo;
        logic [31:0] er;
        logic        ez, ee;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        #1;
        if (v0 && v1) g = (exp_last == 1) ? 0 : 1;
        else          g = v1 ? 1 : 0;
        check("idle_ready0", 32'(bus.req0_ready), 32'(g == 0));
        check("idle_ready1", 32'(bus.req1_ready), 32'(g == 1));
        step();
        exp_last = g;
        check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("exec_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        step();
        eo = g ? op1 : op0;
        if (eo == 3'b011) begin
            er = 32'd0; ez = 1'b1; ee = 1'b1;
        end else begin
            er = g ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
            ez = (er == 32'd0); ee = 1'b0;
        end
        check("resp_valid", 32'(bus.rsp_valid), 32'd1);
        check("resp_result", bus.rsp_result, er);
        check("resp_zero", 32'(bus.rsp_zero), 32'(ez));
        check("resp_err", 32'(bus.rsp_err), 32'(ee));
        check("resp_id", 32'(bus.rsp_id), 32'(g));
        check("resp_ops_done", 32'(bus.ops_done), 32'(exp_done));
        for (int i = 0; i < hold; i++) begin
            step();
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_result", bus.rsp_result, er);
            check("stall_id_err_zero", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_zero}),
                  32'({g[0], ee, ez}));
            check("stall_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_done = (exp_done + 1) % CNT_MOD;
        check("post_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_ops_done", 32'(bus.ops_done), 32'(exp_done));
        check("post_result_held", bus.rsp_result, er);
        gid = g;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int gid;
        int sel;
        rst_n          = 1'b0;
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_op = 3'd0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 3'd0;
        step();
        step();
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check("rst_result", bus.rsp_result, 32'd0);
        check("rst_flags", 32'({bus.rsp_zero, bus.rsp_id, bus.rsp_err}), 32'd0);
        check("rst_ops_done", 32'(bus.ops_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie from reset alternates grants 0,1,0,1; ops_done walks 1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 32'd10 + 32'(i), 32'd1, 3'd2, 32'd20 + 32'(i), 32'd2, 3'd6, 0, gid);
            check("tie_grant", 32'(gid), 32'(i % 2));
        end
        check("wrap_zero", 32'(bus.ops_done), 32'd0);

        txn(1, 0, 32'd5, 32'd3, 3'd2, 32'd0, 32'd0, 3'd0, 0, gid);
        check("single_result", bus.rsp_result, 32'd8);
        check("single_ops_done_wrap", 32'(bus.ops_done), 32'd1);

        txn(0, 1, 32'd0, 32'd0, 3'd0, 32'hF0F0_0000, 32'h0000_0F0F, 3'd1, 5, gid);

        txn(1, 0, 32'd3, 32'd3, 3'd6, 32'd0, 32'd0, 3'd0, 0, gid);
        check("sub_zero", 32'(bus.rsp_zero), 32'd1);
        txn(0, 1, 32'd0, 32'd0, 3'd0, 32'd1, 32'hFFFF_FFFF, 3'd7, 1, gid);
        check("sltu_one", bus.rsp_result, 32'd1);
        txn(1, 1, 32'hDEAD_BEEF, 32'd7, 3'd3, 32'hDEAD_BEEF, 32'd7, 3'd3, 0, gid);
        check("illegal_err", 32'({bus.rsp_err, bus.rsp_zero}), 32'd3);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(1, 3);
            txn(sel[0], sel[1], rand_word(), rand_word(), 3'($urandom_range(0, 7)),
                rand_word(), rand_word(), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), gid);
        end

        // Leave a nonzero response, then reset while the next op is in EXEC.
        txn(1, 0, 32'h1234_0000, 32'h0000_5678, 3'd1, 32'd0, 32'd0, 3'd0, 0, gid);
        bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_op = 3'd2;
        bus.req1_valid = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check("midrst_result", bus.rsp_result, 32'd0);
        check("midrst_flags", 32'({bus.rsp_zero, bus.rsp_id, bus.rsp_err}), 32'd0);
        check("midrst_ops_done", 32'(bus.ops_done), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1;
        exp_done = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("after_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("after_rst_ops_done", 32'(bus.ops_done), 32'd0);
        end
        txn(1, 1, 32'd1, 32'd2, 3'd0, 32'd3, 32'd4, 3'd0, 0, gid);
        check("after_rst_tie", 32'(gid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 req0_op / req1_op  input  3  ALU control code.
REQ-008 rsp_valid  output  1  response held.
REQ-009 rsp_ready  input  1  consumer accepts response.
REQ-010 rsp_result  output  32  ALU result.
REQ-011 rsp_zero  output  1  result equals zero.
REQ-012 rsp_id  output  1  requester that issued the op.
REQ-013 rsp_err  output  1  illegal op code.
REQ-014 ops_done  output  CNT_W  count of completed responses.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; reset state IDLE.
REQ-016 IDLE: reqN_ready is 1 only for the granted requester; all readys are 0 in EXEC and RESP.
REQ-017 Grant: a single valid requester wins; when both are valid, the requester not granted last wins (round-robin); last_grant resets to 1, so req0 wins the first tie.
REQ-018 Accept on valid&&ready: latch a, b, op and id; update last_grant; IDLE->EXEC.
REQ-019 EXEC, one cycle: latched operands drive the ALU; result and zero are registered at cycle end; EXEC->RESP unconditionally.
REQ-020 Op codes: 000 and, 001 or, 010 add (mod 2^32), 100 a&~b, 101 a|~b, 110 sub (mod 2^32), 111 unsigned a<b giving 1 or 0.
REQ-021 Op 011 is illegal: rsp_result=0, rsp_zero=1, rsp_err=1; legal ops give rsp_err=0.
REQ-022 Latency: accept in cycle N gives rsp_valid=1 from cycle N+2.
REQ-023 RESP: rsp_valid=1, and all rsp_* outputs stay stable until rsp_valid&&rsp_ready.
REQ-024 On response handshake: RESP->IDLE and ops_done increments; a new accept occurs no earlier than the next cycle (max throughput 1 op per 3 cycles).
REQ-025 ops_done wraps from 2^CNT_W-1 to 0.
REQ-026 rsp_valid=0 outside RESP; rsp_* data holds its last value when rsp_valid=0.
REQ-027 A requester dropping valid without a handshake is not an error; no state changes.

Reset
REQ-028 rst_n low immediately forces: state IDLE, rsp_valid 0, req0_ready/req1_ready 0, rsp_result 0, rsp_zero 0, rsp_id 0, rsp_err 0, ops_done 0, last_grant 1.
REQ-029 Reset asserted in EXEC or RESP discards the in-flight op; no response is produced afterwards.
REQ-030 The first accept is possible in the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package alu_pkg holds the 3-bit op code constants, the ALU_OP_ILLEGAL value (011) and the FSM state enum.
REQ-032 The block instantiates exactly one alu sub-module (32-bit a/b, 3-bit alucont, result, zero) as the shared datapath.
REQ-033 The illegal-op override is applied in alu_arbiter, outside the alu instance.

Verification
REQ-034 Single op: req0 a=5, b=3, op=010, rsp_ready=1 -> rsp_valid 2 cycles after accept, result=8, zero=0, id=0, ops_done=1.
REQ-035 Tie: both valid from reset -> req0 granted first, req1 next; with both held, grants alternate 0,1,0,1.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req readys 0; the handshake then returns the FSM to IDLE.
REQ-037 Ops and edges: a=3, b=3, op=110 gives result 0, zero=1; a=1, b=0xFFFFFFFF, op=111 gives 1; op=011 gives err=1, result=0.
REQ-038 Reset mid-op: rst_n low during EXEC -> outputs at reset values, no rsp_valid after release, ops_done=0.
REQ-039 Wrap: CNT_W=2, five ops -> ops_done sequence 1,2,3,0,1.
